fireball_motion: RTL

- Per-frame motion controller for a single fireball sprite.
- Spawns the fireball on a launch request and advances its coordinates by a latched signed velocity once per frame tick.
- Despawns the fireball when the downstream out-of-screen checker flags it, or when its lifetime expires.
- Drives the coordinate/speed inputs of the screen-bounds checker, consumes that checker's is-out flag, and feeds the sprite renderer and game logic.

---
 rtl/fireball_pkg.sv | 15 +
 rtl/fireball_axis_step.sv | 55 +++++
 rtl/fireball_motion.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fireball_pkg.sv
// Shared types and constants for the fireball sprite motion block.
package fireball_pkg;
  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOLDOWN
  } state_t;

  typedef logic [9:0] coord_t;

  localparam int FIREBALL_W = 64;
  localparam int FIREBALL_H = 64;
  localparam int SCREEN_W   = 800;
  localparam int SCREEN_H   = 600;
endpackage

// File: rtl/fireball_axis_step.sv
// One axis of fireball motion: latched coord/speed/dir, stepped by +/- speed.
module fireball_axis_step (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [9:0] coord_i,
  input  logic [9:0] speed_i,
  input  logic       dir_i,
  output logic [9:0] coord_o,
  output logic [9:0] speed_o
);
  import fireball_pkg::*;

  coord_t coord_q, coord_d;
  coord_t speed_q, speed_d;
  logic   dir_q, dir_d;
  logic [10:0] sum;

  always_comb begin
    sum = dir_q ? ({1'b0, coord_q} - {1'b0, speed_q})
                : ({1'b0, coord_q} + {1'b0, speed_q});
    coord_d = coord_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    if (load_i) begin
      coord_d = coord_i;
      speed_d = speed_i;
      dir_d   = dir_i;
    end else if (step_i) begin
      coord_d = sum[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coord_q <= '0;
      speed_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      coord_q <= coord_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
    end
  end

  // The bounds checker must despawn before a step could wrap.
  always_ff @(posedge clk) begin
    if (rst_n && step_i && !load_i)
      assert (!sum[10]) else $error("fireball axis step wrapped");
  end

  assign coord_o = coord_q;
  assign speed_o = speed_q;
endmodule

// File: rtl/fireball_motion.sv
// Fireball spawn / per-frame motion / despawn controller.
module fireball_motion #(
  parameter int SCREEN_W        = 800,
  parameter int SCREEN_H        = 600,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int MAX_FRAMES      = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic [9:0] launch_h_coord,
  input  logic [9:0] launch_v_coord,
  input  logic [9:0] launch_h_speed,
  input  logic [9:0] launch_v_speed,
  input  logic       launch_h_dir,
  input  logic       launch_v_dir,
  input  logic       fireball_is_out,
  output logic [9:0] fireball_h_coord,
  output logic [9:0] fireball_v_coord,
  output logic [9:0] fireball_h_speed,
  output logic [9:0] fireball_v_speed,
  output logic       fireball_active,
  output logic       fireball_done,
  output logic       launch_ready
);
  import fireball_pkg::*;

  localparam logic [7:0] LIFE_LAST = 8'(MAX_FRAMES - 1);
  localparam logic [7:0] COOL_INIT = 8'(COOLDOWN_FRAMES - 1);

  state_t     state_q, state_d;
  logic [7:0] life_q, life_d;
  logic [7:0] cool_q, cool_d;
  logic       done_q, done_d;
  logic       load, step;

  always_comb begin
    state_d = state_q;
    life_d  = life_q;
    cool_d  = cool_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          load    = 1'b1;
          life_d  = '0;
          state_d = FLYING;
        end
      end
      FLYING: begin
        if (frame_tick) begin
          if (fireball_is_out || life_q == LIFE_LAST) begin
            state_d = COOLDOWN;
            cool_d  = COOL_INIT;
            done_d  = 1'b1;
          end else begin
            step   = 1'b1;
            life_d = life_q + 8'd1;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          if (cool_q == '0) state_d = IDLE;
          else cool_d = cool_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      life_q  <= '0;
      cool_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      life_q  <= life_d;
      cool_q  <= cool_d;
      done_q  <= done_d;
    end
  end

  fireball_axis_step u_h (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .step_i  (step),
    .coord_i (launch_h_coord),
    .speed_i (launch_h_speed),
    .dir_i   (launch_h_dir),
    .coord_o (fireball_h_coord),
    .speed_o (fireball_h_speed)
  );

  fireball_axis_step u_v (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .step_i  (step),
    .coord_i (launch_v_coord),
    .speed_i (launch_v_speed),
    .dir_i   (launch_v_dir),
    .coord_o (fireball_v_coord),
    .speed_o (fireball_v_speed)
  );

  // An in-bounds verdict means the whole sprite sits on screen.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == FLYING && !fireball_is_out)
      assert (int'(fireball_h_coord) + FIREBALL_W <= SCREEN_W &&
              int'(fireball_v_coord) + FIREBALL_H <= SCREEN_H)
      else $error("fireball in-bounds verdict off screen");
  end

  assign fireball_active = (state_q == FLYING);
  assign launch_ready    = (state_q == IDLE);
  assign fireball_done   = done_q;
endmodule
